// File: rtl/ram_march_bist_if.sv
// RAM port bundle between the march BIST engine and a single-port RAM.
// The engine (master) drives we/addr/d and reads q back.
interface ram_march_bist_if #(
    parameter int Data_width = 32,
    parameter int Addr_width = 7
);
    logic                  ram_we;
    logic [Addr_width-1:0] ram_addr;
    logic [Data_width-1:0] ram_d;
    logic [Data_width-1:0] ram_q;

    modport master (
        output ram_we,
        output ram_addr,
        output ram_d,
        input  ram_q
    );

    modport slave (
        input  ram_we,
        input  ram_addr,
        input  ram_d,
        output ram_q
    );
endinterface

// File: rtl/ram_march_bist.sv
// ram_march_bist: two-phase (pattern / complement) write-read BIST engine.
// Drives the RAM port combinationally and compares q one cycle after each read.
module ram_march_bist #(
    parameter int Data_width = 32,
    parameter int Addr_width = 7
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [Data_width-1:0] seed,
    ram_march_bist_if.master      ram,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [Addr_width+1:0] err_count,
    output logic [Addr_width-1:0] fail_addr,
    output logic                  fail_phase
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_WR0,
        S_RD0,
        S_WR1,
        S_RD1,
        S_FIN,
        S_DONE
    } state_t;

    localparam logic [Addr_width-1:0] A_MAX   = '1;
    localparam logic [Addr_width+1:0] ERR_MAX = '1;

    state_t                r_state;
    state_t                w_next;
    logic [Addr_width-1:0] r_a;
    logic [Data_width-1:0] r_seed;
    logic                  r_cmp_v;
    logic [Addr_width-1:0] r_cmp_a;
    logic                  r_cmp_ph;
    logic [Addr_width+1:0] r_err;
    logic [Addr_width-1:0] r_fail_addr;
    logic                  r_fail_ph;
    logic                  r_done;

    logic                  w_last;
    logic                  w_accept;
    logic                  w_scan;
    logic                  w_rd;
    logic                  w_we;
    logic [Addr_width-1:0] w_addr;
    logic [Data_width-1:0] w_d;
    logic                  w_busy;
    logic                  w_miss;

    // Ex(a): seed XOR zero-extended address, inverted for phase 1.
    function automatic logic [Data_width-1:0] f_expect(
        input logic [Data_width-1:0] s,
        input logic [Addr_width-1:0] a,
        input logic                  ph
    );
        logic [Data_width-1:0] e;
        e = s ^ Data_width'(a);
        return ph ? ~e : e;
    endfunction

    assign w_last   = (r_a == A_MAX);
    assign w_accept = start && (r_state == S_IDLE || r_state == S_DONE);
    assign w_rd     = (r_state == S_RD0) || (r_state == S_RD1);
    assign w_scan   = w_rd || (r_state == S_WR0) || (r_state == S_WR1);
    assign w_miss   = r_cmp_v &&
                      (ram.ram_q != f_expect(r_seed, r_cmp_a, r_cmp_ph));

    // Next-state decode and RAM port / busy outputs from the current state.
    always_comb begin
        w_next = r_state;
        w_we   = 1'b0;
        w_addr = '0;
        w_d    = '0;
        w_busy = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (start) w_next = S_WR0;
            end
            S_WR0: begin
                w_we   = 1'b1;
                w_addr = r_a;
                w_d    = f_expect(r_seed, r_a, 1'b0);
                w_busy = 1'b1;
                if (w_last) w_next = S_RD0;
            end
            S_RD0: begin
                w_addr = r_a;
                w_busy = 1'b1;
                if (w_last) w_next = S_WR1;
            end
            S_WR1: begin
                w_we   = 1'b1;
                w_addr = r_a;
                w_d    = f_expect(r_seed, r_a, 1'b1);
                w_busy = 1'b1;
                if (w_last) w_next = S_RD1;
            end
            S_RD1: begin
                w_addr = r_a;
                w_busy = 1'b1;
                if (w_last) w_next = S_FIN;
            end
            S_FIN: begin
                w_busy = 1'b1;
                w_next = S_DONE;
            end
            S_DONE: begin
                if (start) w_next = S_WR0;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Address counter: sweeps every address, wraps to 0 on each phase change.
    always_ff @(posedge clk) begin
        if (!rst_n)      r_a <= '0;
        else if (w_scan) r_a <= r_a + 1'b1;
        else             r_a <= '0;
    end

    // Compare pipeline: remember which read is due back on q next cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cmp_v  <= 1'b0;
            r_cmp_a  <= '0;
            r_cmp_ph <= 1'b0;
        end else begin
            r_cmp_v  <= w_rd;
            r_cmp_a  <= r_a;
            r_cmp_ph <= (r_state == S_RD1);
        end
    end

    // Run results: seed capture, error count, first failure, done flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_seed      <= '0;
            r_err       <= '0;
            r_fail_addr <= '0;
            r_fail_ph   <= 1'b0;
            r_done      <= 1'b0;
        end else if (w_accept) begin
            r_seed      <= seed;
            r_err       <= '0;
            r_fail_addr <= '0;
            r_fail_ph   <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            if (r_state == S_FIN) r_done <= 1'b1;
            if (w_miss) begin
                if (r_err != ERR_MAX) r_err <= r_err + 1'b1;
                if (r_err == '0) begin
                    r_fail_addr <= r_cmp_a;
                    r_fail_ph   <= r_cmp_ph;
                end
            end
        end
    end

    assign ram.ram_we   = w_we;
    assign ram.ram_addr = w_addr;
    assign ram.ram_d    = w_d;

    assign busy       = w_busy;
    assign done       = r_done;
    assign pass       = r_done && (r_err == '0);
    assign err_count  = r_err;
    assign fail_addr  = r_fail_addr;
    assign fail_phase = r_fail_ph;
endmodule

// File: doc/ram_march_bist.md
# ram_march_bist

Built-in self-test engine for the single-port synchronous RAM (1-cycle registered read, read-before-write on same-address access). It sits directly upstream of the RAM and owns its `we`/`address`/`d` ports during test, reading back through `q`. A run performs two write/read phases (a true pattern, then its complement) over every address and reports pass/fail, the error count and the first failing location.

## Interface
- `Data_width`, 32, RAM word width in bits.
- `Addr_width`, 7, RAM address width; depth is 2**Addr_width.

- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  synchronous reset, active-low: sampled on the rising edge of `clk`, no asynchronous path.
- `start`  in  1  single-cycle request; ignored unless the engine is idle.
- `seed`  in  Data_width  base pattern, captured on the accepted `start`.
- `ram_we`  out  1  to RAM `we`.
- `ram_addr`  out  Addr_width  to RAM `address`.
- `ram_d`  out  Data_width  to RAM `d`.
- `ram_q`  in  Data_width  from RAM `q`.
- `busy`  out  1  high from the cycle after an accepted `start` until `done` rises.
- `done`  out  1  level; high after a run completes, cleared by the next accepted `start`.
- `pass`  out  1  valid while `done` is high; equals (`err_count` == 0).
- `err_count`  out  Addr_width+2  number of mismatching reads in the run, saturating at its all-ones value.
- `fail_addr`  out  Addr_width  address of the first mismatch; 0 if there is none.
- `fail_phase`  out  1  phase (0 or 1) of the first mismatch; 0 if there is none.

## Operation
- States: IDLE, WR0, RD0, WR1, RD1, FIN, DONE.
- Address counter `a` runs 0..2**Addr_width-1 in each WR/RD state, then wraps to 0 on the state change.
- Expected word: E0(a) = seed_r XOR zero-extended a. E1(a) = ~E0(a).
- WRx: `ram_we`=1, `ram_addr`=a, `ram_d`=Ex(a).
- RDx: `ram_we`=0, `ram_addr`=a, `ram_d`=0.
- IDLE, FIN, DONE: `ram_we`=0, `ram_addr`=0, `ram_d`=0.
- `ram_*` outputs are combinational from the state, `a` and seed_r. The RAM samples them at the edge that ends the cycle.
- Compare pipeline:
  - On each RD cycle, register cmp_v=1, cmp_a=a and cmp_ph=x at the closing edge.
  - In the next cycle `ram_q` holds ram[cmp_a].
  - At the edge ending that cycle, if cmp_v and `ram_q` != E_cmp_ph(cmp_a): increment `err_count` (saturating). If this is the first mismatch, latch `fail_addr`/`fail_phase`.
- The compare of RD0's last address overlaps the first WR1 cycle. This is legal because the compare uses `q` from before that edge.
- Transitions:
  - IDLE→WR0 on `start`: capture seed, clear `err_count`, `fail_*`, `done`.
  - WR0→RD0→WR1→RD1 each at a==max.
  - RD1→FIN at a==max.
  - FIN (1 cycle, finishes the last compare)→DONE.
  - DONE→WR0 on `start`; otherwise stay in DONE.
- `start` while busy, or in FIN: ignored.
- Reset (any state, including mid-run):
  - state IDLE, `a`=0, cmp_v=0.
  - All outputs 0, including `done`, `busy`, `pass`, `err_count`, `fail_*` and `ram_we`.
  - RAM contents are not touched.

## Timing
- `start` is sampled at edge S. WR0 addresses 0..D-1 occupy cycles S+1..S+D (D = 2**Addr_width).
- RD0 occupies cycles S+D+1..S+2D, WR1 the next D cycles, RD1 the next D cycles, then FIN for one cycle.
- `done` rises, and `busy` falls, at edge S+4D+1.
  - Default D=128: 513 cycles after `start`.
- Read latency is 1 cycle. Each mismatch is counted 2 edges after its RD cycle begins.
- `pass` is 0 whenever `done` is 0.

## Test plan
- Reset, then idle 5 cycles → all outputs 0; `ram_we` never asserted.
- Good RAM model, `seed`=32'hA5A5_0000, start:
  - `ram_d`=32'hA5A5_0000 at addr 0 and 32'hA5A5_007F at addr 127 in WR0.
  - Addr 5 in WR1 gets 32'h5A5A_FFFA.
  - `done` at edge S+513, `pass`=1, `err_count`=0.
- RAM model with bit 3 stuck-at-1 at addr 0x40, `seed`=0:
  - Phase 0 expects 0x40 (bit 3 clear), so a mismatch.
  - Phase 1 expects ~0x40 (bit 3 set), so it passes.
  - Result: `err_count`=1, `fail_addr`=0x40, `fail_phase`=0, `pass`=0.
- RAM model with bit 0 stuck-at-0 at every address:
  - Errors at all odd addresses in phase 0 (64) and all even addresses in phase 1 (64) → `err_count`=128.
  - `fail_addr`=1, `fail_phase`=0.
- Pulse `start` at cycles 10 and 300 after the first accepted start → second pulse ignored, completion still at S+513.
  - Then start again from DONE → `done` clears next edge and the run repeats.
- Assert `rst_n`=0 for 1 cycle in the middle of RD0 → next edge state IDLE, `ram_we`=0, `busy`=0, `err_count`=0.
  - A following `start` runs the full 513 cycles.
